// File: rtl/board_pkg.sv
// board_pkg: shared board sprite types, geometry and default rows
package board_pkg;

    typedef enum logic [1:0] {AT_TOP, MOVING_DOWN, AT_BOTTOM, MOVING_UP} board_state_e;

    localparam int BOARD_W         = 68;
    localparam int BOARD_H         = 12;
    localparam int PURPLE_X        = 556;
    localparam int PURPLE_Y_TOP    = 204;
    localparam int PURPLE_Y_BOTTOM = 252;
    localparam int YELLOW_Y_TOP    = 300;
    localparam int YELLOW_Y_BOTTOM = 348;

endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: synchronises vsync into Clk and emits one registered pulse per rising edge
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    logic s1, s2, s3;

    // two-flop synchroniser, edge history and registered rising-edge pulse
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) {s1, s2, s3, tick} <= '0;
        else begin
            s1   <= frame_clk;
            s2   <= s1;
            s3   <= s2;
            tick <= s2 & ~s3;
        end

endmodule

// File: rtl/board_motion.sv
// board_motion: per-frame platform position controller; BOARD_MOTION_LATCH_EN selects press-to-toggle request
module board_motion
    import board_pkg::*;
#(
    parameter int BOARD_X  = PURPLE_X,
    parameter int Y_TOP    = PURPLE_Y_TOP,
    parameter int Y_BOTTOM = PURPLE_Y_BOTTOM,
    parameter int STEP     = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       button_on,
    input  logic       obstructed,
    output logic [9:0] board_x,
    output logic [9:0] board_y,
    output logic       is_moving,
    output logic       at_top,
    output logic       at_bottom
);
    localparam logic [9:0] YT = 10'(Y_TOP);
    localparam logic [9:0] YB = 10'(Y_BOTTOM);
    localparam logic [9:0] ST = 10'(STEP);

    logic         tick, want_down, go_down, go_up;
    logic [9:0]   y_dn, y_up;
    board_state_e state, nxt;

    frame_tick_sync u_sync (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .tick(tick));

`ifdef BOARD_MOTION_LATCH_EN
    logic btn_q;

    // each fresh press flips the lowering request
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            btn_q     <= 1'b0;
            want_down <= 1'b0;
        end else begin
            btn_q <= button_on;
            if (button_on && !btn_q) want_down <= !want_down;
        end
`else
    assign want_down = button_on;
`endif

    assign board_x = 10'(BOARD_X);
    assign y_dn    = (YB - board_y <= ST) ? YB : board_y + ST;
    assign y_up    = (board_y - YT <= ST) ? YT : board_y - ST;
    assign go_down = want_down && !obstructed && state != AT_BOTTOM;
    assign go_up   = !go_down && (state == MOVING_UP || (!want_down && state != AT_TOP));

    // landing on an end row settles into the matching rest state
    always_comb
        nxt = go_down ? (y_dn == YB ? AT_BOTTOM : MOVING_DOWN) :
              go_up   ? (y_up == YT ? AT_TOP : MOVING_UP) : state;

    // position, state and status flags advance only on the frame tick
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            state     <= AT_TOP;
            board_y   <= YT;
            at_top    <= 1'b1;
            at_bottom <= 1'b0;
            is_moving <= 1'b0;
        end else if (tick) begin
            state     <= nxt;
            board_y   <= go_down ? y_dn : go_up ? y_up : board_y;
            at_top    <= nxt == AT_TOP;
            at_bottom <= nxt == AT_BOTTOM;
            is_moving <= nxt == MOVING_DOWN || nxt == MOVING_UP;
        end

endmodule

// File: tb/tb_board_motion.sv
// tb_board_motion: self-checking bench for board_motion (default and STEP=5 instances)
module tb_board_motion;
    logic       Clk = 0, Reset = 1, frame_clk = 0, button_on = 0, obstructed = 0;
    logic [9:0] bx0, by0, bx5, by5;
    logic       m0, t0, b0, m5, t5, b5;
    int         checks = 0, errors = 0;
    int         y0m = 204, y5m = 204;
    bit         u0, u5, wdm;

    typedef struct {bit b; bit o; int y; int f;} vec_t;
    vec_t tbl[8];

    always #5 Clk = ~Clk;

    board_motion d0 (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .button_on(button_on),
                     .obstructed(obstructed), .board_x(bx0), .board_y(by0), .is_moving(m0),
                     .at_top(t0), .at_bottom(b0));
    board_motion #(.STEP(5)) d5 (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .button_on(button_on),
                     .obstructed(obstructed), .board_x(bx5), .board_y(by5), .is_moving(m5),
                     .at_top(t5), .at_bottom(b5));

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", n, a, e);
        end
    endtask

    // status implied by position: rest rows are the only places the board is idle
    function automatic int fl(input int y);
        return ((y != 204 && y != 252) ? 4 : 0) | (y == 204 ? 2 : 0) | (y == 252 ? 1 : 0);
    endfunction

    // one frame of the platform rules on a plain integer row
    task automatic model(inout int y, inout bit u, input int s, input bit wd, input bit o);
        if (wd && !o && y < 252) begin
            y = (y + s > 252) ? 252 : y + s;
            u = 0;
        end else if (y > 204 && (!wd || u)) begin
            y = (y - s < 204) ? 204 : y - s;
            u = 1;
        end
    endtask

    task automatic model_reset();
        y0m = 204; y5m = 204; u0 = 0; u5 = 0; wdm = 0;
    endtask

    task automatic compare(input string n);
        chk({n, ".y0"}, int'(by0), y0m);
        chk({n, ".f0"}, int'({m0, t0, b0}), fl(y0m));
        chk({n, ".y5"}, int'(by5), y5m);
        chk({n, ".f5"}, int'({m5, t5, b5}), fl(y5m));
    endtask

    // called and returns at a negedge; board must not move before the 4th Clk edge
    task automatic frame(input bit b, input bit o, input string n);
        int py;
        bit wd;
`ifdef BOARD_MOTION_LATCH_EN
        wd = wdm;
`else
        wd = b;
`endif
        button_on = b;
        obstructed = o;
        frame_clk = 1;
        py = int'(by0);
        repeat (3) @(negedge Clk);
        chk({n, ".lat"}, int'(by0), py);
        @(negedge Clk);
        model(y0m, u0, 2, wd, o);
        model(y5m, u5, 5, wd, o);
        compare(n);
        frame_clk = 0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic async_reset(input string n);
        @(negedge Clk);
        #1 Reset = 1;
        #1;
        chk({n, ".async_y"}, int'(by0), 204);
        chk({n, ".async_top"}, int'(t0), 1);
        @(negedge Clk);
        Reset = 0;
        model_reset();
    endtask

    initial begin
        tbl[0] = '{1, 1, 204, 2};
        tbl[1] = '{1, 0, 206, 4};
        tbl[2] = '{1, 0, 208, 4};
        tbl[3] = '{1, 1, 208, 4};
        tbl[4] = '{0, 1, 206, 4};
        tbl[5] = '{1, 1, 204, 2};
        tbl[6] = '{1, 0, 206, 4};
        tbl[7] = '{0, 0, 204, 2};
        repeat (2) @(negedge Clk);
        compare("reset");
        chk("board_x", int'(bx0), 556);
        Reset = 0;
        model_reset();
`ifdef BOARD_MOTION_LATCH_EN
        button_on = 1; @(negedge Clk); button_on = 0; wdm = 1;
        for (int i = 1; i <= 26; i++) frame(0, 0, "latch_dn");
        chk("latch_bottom", int'(by0), 252);
        button_on = 1; @(negedge Clk); button_on = 0; wdm = 0;
        for (int i = 1; i <= 26; i++) frame(0, 0, "latch_up");
        chk("latch_top", int'(by0), 204);
`else
        for (int i = 0; i < 5; i++) frame(0, 0, "idle");
        for (int i = 1; i <= 26; i++) begin
            frame(1, 0, "down");
            if (i == 23) chk("d0_t23", int'(by0), 250);
            if (i == 24) chk("d0_t24", int'(by0), 252);
            if (i == 9) chk("d5_t9", int'(by5), 249);
            if (i == 10) chk("d5_t10", int'(by5), 252);
        end
        for (int i = 1; i <= 26; i++) begin
            frame(0, 0, "up");
            if (i == 9) chk("d5_up9", int'(by5), 207);
            if (i == 10) chk("d5_up10", int'(by5), 204);
            if (i == 24) chk("d0_up24", int'(by0), 204);
        end
        for (int i = 0; i < 8; i++) begin
            frame(tbl[i].b, tbl[i].o, "tbl");
            chk($sformatf("tbl%0d.y", i), int'(by0), tbl[i].y);
            chk($sformatf("tbl%0d.f", i), int'({m0, t0, b0}), tbl[i].f);
        end
        for (int i = 0; i < 13; i++) frame(1, 0, "to230");
        chk("at230", int'(by0), 230);
        for (int i = 0; i < 3; i++) begin
            frame(1, 1, "obst");
            chk("obst_y", int'(by0), 230);
            chk("obst_mv", int'(m0), 1);
        end
        frame(1, 0, "unobst");
        chk("unobst_y", int'(by0), 232);
        async_reset("r1");
        for (int i = 0; i < 8; i++) frame(1, 0, "to220");
        chk("at220", int'(by0), 220);
        frame(0, 0, "rev");
        chk("rev_y", int'(by0), 218);
        chk("rev_mv", int'(m0), 1);
        async_reset("r2");
        compare("post_reset");
        begin
            bit b = 0, o = 0;
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 7) == 0) b = !b;
                o = ($urandom_range(0, 3) == 0);
                frame(b, o, "rand");
            end
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
